pipelined_add_sub: RTL and testbench
====================================

# pipelined_add_sub

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake on both sides. The WIDTH-bit operation is split into CHUNK-bit ripple segments, one segment per pipeline stage, with carries registered between stages. It also produces carry, signed-overflow and zero flags. It is the datapath adder for wider units, and replaces single-cycle fixed-width adders where timing or width demands it.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  A, B and Sub are valid this cycle.
- in_ready  out  1  block accepts the input this cycle.
- Sub  in  1  0 = A+B; 1 = A−B (computed as A + ~B + 1).
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- out_valid  out  1  S and the flags hold a result.
- out_ready  in  1  downstream accepts the result this cycle.
- S  out  WIDTH  result, modulo 2^WIDTH.
- Cout  out  1  carry out of the MSB; in subtract mode 1 = no borrow (A ≥ B unsigned).
- V  out  1  signed overflow.
- Z  out  1  S == 0.

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Stage k (0..STAGES−1) adds bits [k·CHUNK +: CHUNK] of A and B^{WIDTH{Sub}}, plus the carry from stage k−1. The carry-in of stage 0 is Sub.
- Operand skew: the upper chunks of A and B-xor-Sub travel in registers alongside the data until their stage. Lower sum chunks are carried forward (deskew), so S emerges aligned.
- Each stage holds a valid bit. The sum, carry and deskew state of an entry move together.
- V = (a_msb == b'_msb) && (S_msb != a_msb), where b' = B^{WIDTH{Sub}}. It is computed in the final stage from the registered MSBs.
- Z is computed combinationally from the final-stage S register.
- Stall: stall = out_valid && !out_ready. The whole pipeline holds when stall = 1; there are no internal bubbles to compress.
- in_ready = !stall. This is combinational from out_valid and out_ready.
- When not stalled, every stage advances. An empty slot advances as valid = 0.
- The output registers hold S, Cout, V and Z stable while out_valid && !out_ready.
- Results leave in input order. Throughput is one result per cycle while out_ready = 1.

## Timing
- Reset (asynchronous, rst_n = 0): all stage valid bits = 0, out_valid = 0, S = 0, Cout = 0, V = 0, Z = 1, in_ready = 1.
- Reset may assert mid-operation. All in-flight entries are discarded, and outputs take their reset values immediately without waiting for clk.
- Latency is STAGES cycles. An input accepted at edge n gives out_valid = 1 after edge n+STAGES−1, provided there was no stall in between.
- Each cycle of stall adds exactly one cycle of latency to every entry in flight.
- Output transfer and input acceptance in the same cycle are legal. The pipeline advances and holds no extra entries.
- Capacity is STAGES entries; there is no skid buffer.
- Boundary cases:
  - Degenerate case CHUNK = WIDTH: STAGES = 1, latency 1.
  - Wrap-around: sums wrap modulo 2^WIDTH, and Cout reports the carry.
  - Sub toggling between back-to-back inputs is legal. Each entry carries its own Sub-derived operands.

## Test plan
- WIDTH = 16, CHUNK = 4. Single add 0x1234 + 0x0FFF -> after 4 cycles S = 0x2233, Cout = 0, V = 0, Z = 0.
- Subtract 0x0005 − 0x0007 -> S = 0xFFFE, Cout = 0 (borrow), V = 0. Subtract 0x8000 − 0x0001 -> S = 0x7FFF, Cout = 1, V = 1.
- Add 0xFFFF + 0x0001 -> S = 0x0000, Cout = 1, Z = 1, V = 0. Add 0x7FFF + 0x0001 -> S = 0x8000, V = 1.
- Stream of 20 random mixed add/sub operations with out_ready held at 1 -> one result per cycle, in order, all matching the reference model; in_ready stays at 1.
- Stream with out_ready randomly deasserted (about 30%) -> no loss or duplication; S and flags stable while stalled; in_ready = 0 exactly when out_valid && !out_ready.
- rst_n pulsed low with 3 entries in flight -> out_valid = 0 and in_ready = 1 immediately; the next accepted input produces the only subsequent result, 4 cycles later.

Source files
------------

// File: rtl/pipelined_add_sub_if.sv
// Handshake and data bundle for the pipelined adder/subtractor.
// The master side drives operands and out_ready; the slave side is the adder.
interface pipelined_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             Sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             V;
    logic             Z;

    modport master (
        output in_valid, Sub, A, B, out_ready,
        input  in_ready, out_valid, S, Cout, V, Z
    );

    modport slave (
        input  in_valid, Sub, A, B, out_ready,
        output in_ready, out_valid, S, Cout, V, Z
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement add/sub: one CHUNK-bit ripple segment per stage,
// carries registered between stages, whole-pipe stall driven by the output side.
module pipelined_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_add_sub_if.slave io
);
    localparam int STAGES = WIDTH / CHUNK;
    // Bank j holds B' bits above chunk j; all banks are packed back to back here.
    localparam int BX_BITS = (STAGES - 1) * WIDTH - CHUNK * (STAGES - 1) * STAGES / 2;
    localparam int BX_W    = (BX_BITS > 0) ? BX_BITS : 1;

    logic [STAGES-1:0]            vld_q, vld_d;
    logic [STAGES-1:0]            cy_q, cy_d, cy_nxt;
    // acc bank k = {A bits not yet added, sum bits already produced}
    logic [STAGES-1:0][WIDTH-1:0] acc_q, acc_d, acc_nxt;
    logic [BX_W-1:0]              bx_q, bx_d, bx_nxt;
    logic                         v_q, v_d, v_nxt;
    logic                         stall;
    logic [WIDTH-1:0]             b_eff;

    assign b_eff = io.B ^ {WIDTH{io.Sub}};
    assign stall = vld_q[STAGES-1] && !io.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * CHUNK;
        logic [WIDTH-1:0]    acc_in;
        logic [WIDTH-1:0]    acc_o;
        logic [WIDTH-LO-1:0] bx_in;
        logic                cy_in;
        logic [CHUNK:0]      sum;

        if (k == 0) begin : g_head
            assign acc_in = io.A;
            assign bx_in  = b_eff;
            assign cy_in  = io.Sub;
        end else begin : g_body
            localparam int OFF_IN = (k - 1) * WIDTH - CHUNK * (k - 1) * k / 2;
            assign acc_in = acc_q[k-1];
            assign bx_in  = bx_q[OFF_IN +: WIDTH-LO];
            assign cy_in  = cy_q[k-1];
        end

        assign sum = {1'b0, acc_in[LO +: CHUNK]} + {1'b0, bx_in[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, cy_in};

        always_comb begin
            acc_o              = acc_in;
            acc_o[LO +: CHUNK] = sum[CHUNK-1:0];
        end

        assign acc_nxt[k] = acc_o;
        assign cy_nxt[k]  = sum[CHUNK];

        if (k < STAGES - 1) begin : g_fwd
            localparam int OFF_OUT = k * WIDTH - CHUNK * k * (k + 1) / 2;
            assign bx_nxt[OFF_OUT +: WIDTH-LO-CHUNK] = bx_in[WIDTH-LO-1:CHUNK];
        end else begin : g_last
            // Operand MSBs reach the last stage together with the final sum chunk.
            assign v_nxt = (acc_in[WIDTH-1] == bx_in[WIDTH-LO-1])
                        && (acc_o[WIDTH-1] != acc_in[WIDTH-1]);
        end
    end

    if (STAGES == 1) begin : g_nobx
        assign bx_nxt = '0;
    end

    always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        acc_d = acc_q;
        bx_d  = bx_q;
        v_d   = v_q;
        if (!stall) begin
            vld_d[0] = io.in_valid;
            for (int k = 1; k < STAGES; k++) vld_d[k] = vld_q[k-1];
            cy_d  = cy_nxt;
            acc_d = acc_nxt;
            bx_d  = bx_nxt;
            v_d   = v_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            acc_q <= '0;
            bx_q  <= '0;
            v_q   <= 1'b0;
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            acc_q <= acc_d;
            bx_q  <= bx_d;
            v_q   <= v_d;
        end
    end

    assign io.in_ready  = !stall;
    assign io.out_valid = vld_q[STAGES-1];
    assign io.S         = acc_q[STAGES-1];
    assign io.Cout      = cy_q[STAGES-1];
    assign io.V         = v_q;
    assign io.Z         = (acc_q[STAGES-1] == '0);
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed and randomised checks of pipelined_add_sub against an arithmetic
// reference model with an in-order scoreboard.
module tb_pipelined_add_sub;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_out = 0;
    res_t exp_q[$];

    pipelined_add_sub_if #(.WIDTH(W)) io ();

    pipelined_add_sub #(.WIDTH(W), .CHUNK(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: true integer sum/difference, then wrap, carry and range test.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        res_t r;
        int   ua, ub, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            r.s = W'(ua - ub);
            r.c = (ua >= ub);
            sr  = sa - sb;
        end else begin
            r.s = W'(ua + ub);
            r.c = ((ua + ub) > 65535);
            sr  = sa + sb;
        end
        r.v = (sr > 32767) || (sr < -32768);
        r.z = (r.s == '0);
        return r;
    endfunction

    // Scoreboard and protocol monitor, sampled on the falling edge.
    initial begin : mon
        logic   stalled_prev;
        res_t   held;
        res_t   got;
        res_t   e;
        stalled_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                stalled_prev = 1'b0;
                continue;
            end
            got = '{s: io.S, c: io.Cout, v: io.V, z: io.Z};
            check("in_ready_rule", 32'(io.in_ready), 32'(!(io.out_valid && !io.out_ready)));
            if (stalled_prev) begin
                check("stall_valid_hold", 32'(io.out_valid), 32'd1);
                check("stall_data_hold", 32'(got), 32'(held));
            end
            if (io.out_valid && io.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("S", 32'(io.S), 32'(e.s));
                    check("Cout", 32'(io.Cout), 32'(e.c));
                    check("V", 32'(io.V), 32'(e.v));
                    check("Z", 32'(io.Z), 32'(e.z));
                end
                n_out++;
            end
            if (io.in_valid && io.in_ready) exp_q.push_back(model(io.A, io.B, io.Sub));
            stalled_prev = io.out_valid && !io.out_ready;
            held = got;
        end
    end

    // Called right after a rising edge with the pipeline empty and out_ready = 1.
    task automatic single_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                             input logic [W-1:0] es, input logic ec, input logic ev, input logic ez);
        int cnt;
        io.A = a; io.B = b; io.Sub = sub; io.in_valid = 1'b1; io.out_ready = 1'b1;
        @(posedge clk); #1 io.in_valid = 1'b0;
        cnt = 0;
        do begin
            @(posedge clk); cnt++;
            @(negedge clk);
        end while (!io.out_valid && cnt < 10);
        check("latency", 32'(cnt), 32'd3);
        check("lit_S", 32'(io.S), 32'(es));
        check("lit_Cout", 32'(io.Cout), 32'(ec));
        check("lit_V", 32'(io.V), 32'(ev));
        check("lit_Z", 32'(io.Z), 32'(ez));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(io.out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(io.in_ready), 32'd1);
        check({tag, "_S"}, 32'(io.S), 32'd0);
        check({tag, "_Cout"}, 32'(io.Cout), 32'd0);
        check({tag, "_V"}, 32'(io.V), 32'd0);
        check({tag, "_Z"}, 32'(io.Z), 32'd1);
    endtask

    initial begin : drv
        int n0;
        int guard;
        io.in_valid = 1'b0; io.Sub = 1'b0; io.A = '0; io.B = '0; io.out_ready = 1'b1;
        #1 check_reset_outputs("rst");
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        single_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        single_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        single_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        single_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        single_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

        // Back-to-back stream, no backpressure.
        n0 = n_out;
        for (int i = 0; i < 20; i++) begin
            io.A = W'($urandom); io.B = W'($urandom); io.Sub = 1'($urandom_range(0, 1));
            io.in_valid = 1'b1;
            check("stream_in_ready", 32'(io.in_ready), 32'd1);
            @(posedge clk); #1;
        end
        io.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stream_count", 32'(n_out - n0), 32'd20);
        @(posedge clk); #1;

        // Random backpressure.
        for (int i = 0; i < 60; i++) begin
            io.A = W'($urandom); io.B = W'($urandom); io.Sub = 1'($urandom_range(0, 1));
            io.in_valid = ($urandom_range(0, 9) < 8);
            io.out_ready = ($urandom_range(0, 9) >= 3);
            @(posedge clk); #1;
        end
        io.in_valid = 1'b0; io.out_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || io.out_valid) && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_out_valid", 32'(io.out_valid), 32'd0);

        // Reset with three entries in flight.
        for (int i = 0; i < 3; i++) begin
            io.A = 16'h1111 * W'(i + 1); io.B = 16'h0101; io.Sub = 1'(i); io.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        io.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        n0 = n_out;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        single_op(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1 check("post_reset_count", 32'(n_out - n0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
